// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage driving a 32-bit Wishbone-classic
// data-bus master. Aligns/lane-selects store data, extracts and extends load
// data, and stalls the upstream pipeline while a bus access is outstanding.
// Ports: clk/rst (sync, active-high), flush, ex_mem_reg in, mem_wb_next out,
//        stall_o, wb_* master bus, misaligned_load_o/misaligned_store_o,
//        access_fault_o and fault_addr_o.
// Timing: issue in cycle 0, earliest ack in cycle 1, result in cycle 2.

package mem_stage_pkg;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [4:0]  rd;
    logic        mem_read;
    logic        mem_write;
    logic        mem_unsigned;
    logic [1:0]  mem_width;
    logic        reg_write;
    logic        mem_to_reg;
    logic        valid;
  } ex_mem_reg_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] wb_data;
    logic        valid;
  } mem_wb_reg_t;

endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter bit USE_ERR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  ex_mem_reg_t       ex_mem_reg,
  output mem_wb_reg_t       mem_wb_next,
  output logic              stall_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  output logic [3:0]        wb_sel_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  output logic              misaligned_load_o,
  output logic              misaligned_store_o,
  output logic              access_fault_o,
  output logic [31:0]       fault_addr_o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state, state_next;

  // Latched access context, held for the whole bus cycle and the DONE cycle.
  logic [ADDR_W-1:0] adr_q;
  logic [31:0]       dat_q;
  logic [3:0]        sel_q;
  logic              we_q;
  logic [1:0]        lo_q;
  logic [1:0]        width_q;
  logic              uns_q;
  logic [4:0]        rd_q;
  logic [31:0]       pc_q;
  logic              reg_write_q;
  logic [31:0]       baddr_q;
  logic [31:0]       rdata_q;
  logic              fault_q;
  logic              flushed_q;

  logic        bus_err;
  logic        live;
  logic        misaligned;
  logic        issue;
  logic [3:0]  sel_n;
  logic [31:0] dat_n;
  logic [31:0] shifted;
  logic [31:0] load_data;

  // Fields this stage does not consume: return address is already folded into
  // alu_result by EX, and mem_to_reg is implied by mem_read here.
  logic unused_ok;
  assign unused_ok = ^{ex_mem_reg.pc_plus_4, ex_mem_reg.mem_to_reg};

  assign bus_err = USE_ERR && wb_err_i;
  assign live    = (state == IDLE) && ex_mem_reg.valid && !flush;

  always_comb begin
    misaligned = 1'b0;
    case (ex_mem_reg.mem_width)
      2'b01:   misaligned = ex_mem_reg.alu_result[0];
      2'b10:   misaligned = (ex_mem_reg.alu_result[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign issue = live && (ex_mem_reg.mem_read || ex_mem_reg.mem_write) && !misaligned;

  // Store lane steering; loads reuse the same byte-select pattern.
  always_comb begin
    sel_n = 4'b1111;
    dat_n = ex_mem_reg.rs2_data;
    case (ex_mem_reg.mem_width)
      2'b00: begin
        sel_n = 4'b0001 << ex_mem_reg.alu_result[1:0];
        dat_n = {4{ex_mem_reg.rs2_data[7:0]}};
      end
      2'b01: begin
        sel_n = 4'b0011 << ex_mem_reg.alu_result[1:0];
        dat_n = {2{ex_mem_reg.rs2_data[15:0]}};
      end
      default: begin
        sel_n = 4'b1111;
        dat_n = ex_mem_reg.rs2_data;
      end
    endcase
  end

  // Load extraction from the captured bus word.
  assign shifted = rdata_q >> {lo_q, 3'b000};

  always_comb begin
    load_data = shifted;
    case (width_q)
      2'b00:   load_data = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
      2'b01:   load_data = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      lo_q        <= '0;
      width_q     <= '0;
      uns_q       <= 1'b0;
      rd_q        <= '0;
      pc_q        <= '0;
      reg_write_q <= 1'b0;
      baddr_q     <= '0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
      flushed_q   <= 1'b0;
    end else if (issue) begin
      adr_q       <= {ex_mem_reg.alu_result[ADDR_W-1:2], 2'b00};
      dat_q       <= dat_n;
      sel_q       <= sel_n;
      we_q        <= ex_mem_reg.mem_write;
      lo_q        <= ex_mem_reg.alu_result[1:0];
      width_q     <= ex_mem_reg.mem_width;
      uns_q       <= ex_mem_reg.mem_unsigned;
      rd_q        <= ex_mem_reg.rd;
      pc_q        <= ex_mem_reg.pc;
      reg_write_q <= ex_mem_reg.reg_write && !ex_mem_reg.mem_write;
      baddr_q     <= ex_mem_reg.alu_result;
      fault_q     <= 1'b0;
      flushed_q   <= 1'b0;
    end else if (state == REQ) begin
      // A flush during the bus cycle only poisons the result; the cycle runs on.
      if (flush) flushed_q <= 1'b1;
      if (bus_err)       fault_q <= 1'b1;
      else if (wb_ack_i) rdata_q <= wb_dat_i;
    end
  end

  always_comb begin
    state_next         = state;
    mem_wb_next        = '0;
    stall_o            = 1'b0;
    wb_cyc_o           = 1'b0;
    wb_stb_o           = 1'b0;
    wb_we_o            = we_q;
    wb_adr_o           = adr_q;
    wb_dat_o           = dat_q;
    wb_sel_o           = sel_q;
    misaligned_load_o  = 1'b0;
    misaligned_store_o = 1'b0;
    access_fault_o     = 1'b0;
    fault_addr_o       = '0;

    case (state)
      IDLE: begin
        if (issue) begin
          stall_o    = 1'b1;
          state_next = REQ;
        end else if (live && misaligned && (ex_mem_reg.mem_read || ex_mem_reg.mem_write)) begin
          misaligned_load_o  = ex_mem_reg.mem_read;
          misaligned_store_o = ex_mem_reg.mem_write;
          fault_addr_o       = ex_mem_reg.alu_result;
        end else if (live) begin
          mem_wb_next.pc        = ex_mem_reg.pc;
          mem_wb_next.rd        = ex_mem_reg.rd;
          mem_wb_next.reg_write = ex_mem_reg.reg_write;
          mem_wb_next.wb_data   = ex_mem_reg.alu_result;
          mem_wb_next.valid     = 1'b1;
        end
      end
      REQ: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        stall_o  = 1'b1;
        if (bus_err || wb_ack_i) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
        if (!flush && !flushed_q) begin
          if (fault_q) begin
            access_fault_o = 1'b1;
            fault_addr_o   = baddr_q;
          end else begin
            mem_wb_next.pc        = pc_q;
            mem_wb_next.rd        = rd_q;
            mem_wb_next.reg_write = reg_write_q;
            mem_wb_next.wb_data   = we_q ? 32'b0 : load_data;
            mem_wb_next.valid     = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Reset forces every output low, including the cycle reset is applied in.
    if (rst) begin
      state_next         = IDLE;
      mem_wb_next        = '0;
      stall_o            = 1'b0;
      wb_cyc_o           = 1'b0;
      wb_stb_o           = 1'b0;
      wb_we_o            = 1'b0;
      wb_adr_o           = '0;
      wb_dat_o           = '0;
      wb_sel_o           = '0;
      misaligned_load_o  = 1'b0;
      misaligned_store_o = 1'b0;
      access_fault_o     = 1'b0;
      fault_addr_o       = '0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage. Table of access vectors
// plus hand-written sequences for flush, bus error and reset corner cases;
// completed MEM/WB results are checked against a scoreboard queue.

module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  ex_mem_reg_t ex;
  mem_wb_reg_t mwb;
  logic        stall, cyc, stb, we;
  logic [31:0] adr, dat_o, dat_i, fault_addr;
  logic [3:0]  sel;
  logic        ack, err, mis_ld, mis_st, afault;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32), .USE_ERR(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_mem_reg(ex), .mem_wb_next(mwb),
    .stall_o(stall), .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we),
    .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_sel_o(sel), .wb_dat_i(dat_i),
    .wb_ack_i(ack), .wb_err_i(err), .misaligned_load_o(mis_ld),
    .misaligned_store_o(mis_st), .access_fault_o(afault), .fault_addr_o(fault_addr)
  );

  int checks = 0;
  int failures = 0;
  mem_wb_reg_t exp_q[$];
  mem_wb_reg_t sb_e;

  typedef struct {
    string       name;
    logic        rd_op;
    logic        wr_op;
    logic [1:0]  width;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_wb;
    logic [3:0]  exp_sel;
    logic [31:0] exp_dat;
    logic        exp_mis;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every valid MEM/WB result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && mwb.valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%0h required=none", mwb);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_mem_wb", mwb, sb_e);
      end
    end
  end

  task automatic drive_ex(input logic r, input logic w, input logic [1:0] wd, input logic u,
                          input logic [31:0] a, input logic [31:0] rs2, input logic [31:0] pc);
    ex              = '0;
    ex.alu_result   = a;
    ex.rs2_data     = rs2;
    ex.pc           = pc;
    ex.pc_plus_4    = pc + 32'd4;
    ex.rd           = 5'd7;
    ex.mem_read     = r;
    ex.mem_write    = w;
    ex.mem_unsigned = u;
    ex.mem_width    = wd;
    ex.reg_write    = 1'b1;
    ex.mem_to_reg   = r;
    ex.valid        = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] pc;
    mem_wb_reg_t e;
    pc = 32'h400 + 32'(idx) * 32'd4;
    @(posedge clk); #1;
    drive_ex(v.rd_op, v.wr_op, v.width, v.uns, v.addr, v.rs2, pc);
    if (!v.exp_mis) begin
      e           = '0;
      e.pc        = pc;
      e.rd        = 5'd7;
      e.reg_write = !v.wr_op;
      e.wb_data   = v.wr_op ? 32'h0 : v.exp_wb;
      e.valid     = 1'b1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (v.exp_mis) begin
      chk({v.name, "_mis_ld"}, mis_ld, v.rd_op);
      chk({v.name, "_mis_st"}, mis_st, v.wr_op);
      chk({v.name, "_stall"}, stall, 0);
      chk({v.name, "_cyc"}, cyc, 0);
      chk({v.name, "_fault_addr"}, fault_addr, v.addr);
      chk({v.name, "_valid"}, mwb.valid, 0);
      return;
    end
    if (!v.rd_op && !v.wr_op) begin
      chk({v.name, "_stall"}, stall, 0);
      chk({v.name, "_cyc"}, cyc, 0);
      return;
    end
    chk({v.name, "_issue_stall"}, stall, 1);
    chk({v.name, "_issue_cyc"}, cyc, 0);
    for (int i = 0; i <= v.waits; i++) begin
      @(posedge clk); #1;
      ack   = (i == v.waits);
      dat_i = (i == v.waits) ? v.rdata : 32'h0;
      @(negedge clk);
      chk({v.name, "_req_cyc"}, {cyc, stb, stall}, 3'b111);
      if (i == 0) begin
        chk({v.name, "_we"}, we, v.wr_op);
        chk({v.name, "_adr"}, adr, {v.addr[31:2], 2'b00});
        chk({v.name, "_sel"}, sel, v.exp_sel);
        if (v.wr_op) chk({v.name, "_dat"}, dat_o, v.exp_dat);
      end
    end
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    chk({v.name, "_done_stall_cyc"}, {stall, cyc}, 2'b00);
    chk({v.name, "_done_fault"}, afault, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ex = '0; ack = 1'b0; err = 1'b0; dat_i = '0;

    vt[0]  = '{"lw",      1, 0, 2'b10, 0, 32'h1000, 32'h0,      32'hDEADBEEF, 0, 32'hDEADBEEF, 4'hF,    32'h0,        0};
    vt[1]  = '{"lb",      1, 0, 2'b00, 0, 32'h1003, 32'h0,      32'h80112233, 0, 32'hFFFFFF80, 4'b1000, 32'h0,        0};
    vt[2]  = '{"lbu",     1, 0, 2'b00, 1, 32'h1003, 32'h0,      32'h80112233, 1, 32'h00000080, 4'b1000, 32'h0,        0};
    vt[3]  = '{"lh",      1, 0, 2'b01, 0, 32'h1002, 32'h0,      32'h80112233, 0, 32'hFFFF8011, 4'b1100, 32'h0,        0};
    vt[4]  = '{"lhu",     1, 0, 2'b01, 1, 32'h1002, 32'h0,      32'h80112233, 2, 32'h00008011, 4'b1100, 32'h0,        0};
    vt[5]  = '{"lb_pos",  1, 0, 2'b00, 0, 32'h1001, 32'h0,      32'h80112233, 1, 32'h00000022, 4'b0010, 32'h0,        0};
    vt[6]  = '{"sh",      0, 1, 2'b01, 0, 32'h2002, 32'h1234ABCD, 32'h0,      0, 32'h0,        4'b1100, 32'hABCDABCD, 0};
    vt[7]  = '{"sb",      0, 1, 2'b00, 0, 32'h2001, 32'h1234ABCD, 32'h0,      0, 32'h0,        4'b0010, 32'hCDCDCDCD, 0};
    vt[8]  = '{"sw",      0, 1, 2'b10, 0, 32'h2004, 32'h1234ABCD, 32'h0,      2, 32'h0,        4'hF,    32'h1234ABCD, 0};
    vt[9]  = '{"lw_mis",  1, 0, 2'b10, 0, 32'h1002, 32'h0,      32'h0,        0, 32'h0,        4'h0,    32'h0,        1};
    vt[10] = '{"sw_mis",  0, 1, 2'b10, 0, 32'h3001, 32'h55,     32'h0,        0, 32'h0,        4'h0,    32'h0,        1};
    vt[11] = '{"lh_mis",  1, 0, 2'b01, 0, 32'h1001, 32'h0,      32'h0,        0, 32'h0,        4'h0,    32'h0,        1};
    vt[12] = '{"add",     0, 0, 2'b10, 0, 32'h12345678, 32'h0,  32'h0,        0, 32'h12345678, 4'h0,    32'h0,        0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus", {cyc, stb, we, sel, stall, afault}, 0);
    chk("rst_mwb", mwb, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_bus", {cyc, stb, stall, adr, sel}, 0);
    chk("post_rst_mwb", mwb, 0);

    for (int i = 0; i < 13; i++) run_vec(vt[i], i);

    // Flush in IDLE: nothing issued, nothing written back
    @(posedge clk); #1;
    drive_ex(1, 0, 2'b10, 0, 32'h1000, 32'h0, 32'h500);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_stall", stall, 0);
    chk("flush_idle_mwb", mwb, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    ex.valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_no_cyc", cyc, 0);

    // Flush in 2nd REQ cycle with 3 wait states: cycle completes, result dropped
    @(posedge clk); #1;
    drive_ex(1, 0, 2'b10, 0, 32'h1000, 32'h0, 32'h504);
    @(negedge clk);
    chk("flush_req_issue", stall, 1);
    for (int i = 0; i <= 3; i++) begin
      @(posedge clk); #1;
      ack   = (i == 3);
      flush = (i == 1);
      dat_i = 32'h5555AAAA;
      @(negedge clk);
      chk("flush_req_cyc_held", {cyc, stb}, 2'b11);
    end
    @(posedge clk); #1;
    ack = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_req_done_valid", mwb.valid, 0);
    chk("flush_req_done_fault", afault, 0);
    chk("flush_req_done_stall", stall, 0);

    // Bus error (v=0) and simultaneous ack+err (v=1): fault pulse, no writeback
    for (int v = 0; v < 2; v++) begin
      @(posedge clk); #1;
      drive_ex(1, 0, 2'b10, 0, 32'h1000, 32'h0, 32'h508);
      @(negedge clk);
      for (int i = 0; i <= 1; i++) begin
        @(posedge clk); #1;
        err = (i == 1);
        ack = (i == 1) && (v == 1);
        @(negedge clk);
        chk("err_req_cyc", cyc, 1);
      end
      @(posedge clk); #1;
      err = 1'b0;
      ack = 1'b0;
      @(negedge clk);
      chk("err_fault", afault, 1);
      chk("err_fault_addr", fault_addr, 32'h1000);
      chk("err_valid", mwb.valid, 0);
      @(posedge clk); #1;
      ex.valid = 1'b0;
      @(negedge clk);
      chk("err_fault_one_cycle", afault, 0);
    end

    // Reset asserted while in REQ drops the bus cycle
    @(posedge clk); #1;
    drive_ex(1, 0, 2'b10, 0, 32'h1000, 32'h0, 32'h50C);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_during", {cyc, stb, stall}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    ex.valid = 1'b0;
    @(negedge clk);
    chk("rst_req_after", {cyc, stb, stall}, 3'b000);
    run_vec(vt[12], 20);

    @(posedge clk); #1;
    ex.valid = 1'b0;
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
